commit_tracer: RTL and testbench

COMMIT_TRACER -- requirements
Module: commit_tracer

---
 rtl/commit_tracer.sv | 149 ++++++++++++++
 tb/tb_commit_tracer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_tracer.sv
// commit_tracer
//   Captures retired-instruction records from the core into a small FIFO and
//   streams them to a trace sink with a valid/ready handshake. Also counts
//   retirements and lost records, and watches for ebreak (drain then halt) and
//   for a stalled core (watchdog timeout).
//
// Ports
//   clk, rst          : clock, synchronous active-low reset
//   commit            : retire strobe, one record per high cycle
//   commit_instr      : retired instruction word
//   commit_pc         : PC of the retired instruction
//   commit_pre_pc     : predicted next PC of the retired instruction
//   trace_valid       : a record is presented on trace_data
//   trace_ready       : sink accepts the presented record
//   trace_data        : {instr[159:128], pre_pc[127:64], pc[63:0]}
//   fifo_level        : current FIFO occupancy
//   retired_cnt       : commits observed while running (wraps)
//   drop_cnt          : records lost to overflow (saturates)
//   overflow          : sticky, a record has been lost
//   halted / timeout  : terminal-state flags
module commit_tracer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit,
  input  logic [31:0]              commit_instr,
  input  logic [63:0]              commit_pc,
  input  logic [63:0]              commit_pre_pc,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [159:0]             trace_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [63:0]              retired_cnt,
  output logic [31:0]              drop_cnt,
  output logic                     overflow,
  output logic                     halted,
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(WDOG_LIMIT);
  localparam logic [31:0] EBREAK = 32'h00100073;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t state, stateNext;

  logic [159:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [IW-1:0] idleCnt;

  logic fifoEmpty, fifoFull;
  logic pushReq, pushOk, pop, dropEv;
  logic isEbreak, wdogHit;

  // Handshake and FIFO control
  always_comb begin
    fifoEmpty = (fifo_level == '0);
    fifoFull  = (fifo_level == (AW+1)'(DEPTH));
    pop       = !fifoEmpty && trace_ready;
    pushReq   = (state == RUN) && commit;
    // A full FIFO still accepts the record when a slot frees in the same cycle.
    pushOk    = pushReq && (!fifoFull || pop);
    dropEv    = pushReq && !pushOk;
    isEbreak  = (commit_instr == EBREAK);
    wdogHit   = !commit && (idleCnt == IW'(WDOG_LIMIT - 1));
  end

  // Storage is never reset; the output mux masks it while empty.
  assign trace_valid = !fifoEmpty;
  assign trace_data  = fifoEmpty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst && pushOk) begin
      mem[wrPtr] <= {commit_instr, commit_pre_pc, commit_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_level <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Statistics and watchdog
  always_ff @(posedge clk) begin
    if (!rst) begin
      retired_cnt <= '0;
      drop_cnt    <= '0;
      overflow    <= 1'b0;
      idleCnt     <= '0;
    end else begin
      if (pushReq) retired_cnt <= retired_cnt + 64'd1;
      if (dropEv && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
      if (dropEv) overflow <= 1'b1;
      if (state == RUN) begin
        idleCnt <= commit ? '0 : idleCnt + 1'b1;
      end
    end
  end

  // State machine
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RUN;
      halted  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= stateNext;
      halted  <= (stateNext == HALTED);
      timeout <= (stateNext == TIMEOUT);
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        // ebreak carries a commit, so it naturally wins over the watchdog.
        if (commit && isEbreak) stateNext = DRAIN;
        else if (wdogHit)       stateNext = TIMEOUT;
      end
      DRAIN: begin
        if (fifoEmpty) stateNext = HALTED;
      end
      HALTED:  stateNext = HALTED;
      TIMEOUT: stateNext = TIMEOUT;
      default: stateNext = RUN;
    endcase
  end

endmodule

// File: tb/tb_commit_tracer.sv
// Directed bench for commit_tracer: two instances, one with default watchdog
// for the FIFO/halt scenarios and one with WDOG_LIMIT=16 for the timeout case.
module tb_commit_tracer;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, commit, traceReady;
  logic [31:0]  commitInstr;
  logic [63:0]  commitPc, commitPrePc;
  logic         traceValid;
  logic [159:0] traceData;
  logic [3:0]   fifoLevel;
  logic [63:0]  retiredCnt;
  logic [31:0]  dropCnt;
  logic         overflow, halted, timeout;

  logic         wRst, wCommit, wReady;
  logic         wValid;
  logic [159:0] wData;
  logic [3:0]   wLevel;
  logic [63:0]  wRetired;
  logic [31:0]  wDrop;
  logic         wOverflow, wHalted, wTimeout;

  commit_tracer #(.DEPTH(DEPTH), .WDOG_LIMIT(1024)) dut (
    .clk(clk), .rst(rst), .commit(commit), .commit_instr(commitInstr),
    .commit_pc(commitPc), .commit_pre_pc(commitPrePc),
    .trace_valid(traceValid), .trace_ready(traceReady), .trace_data(traceData),
    .fifo_level(fifoLevel), .retired_cnt(retiredCnt), .drop_cnt(dropCnt),
    .overflow(overflow), .halted(halted), .timeout(timeout)
  );

  commit_tracer #(.DEPTH(DEPTH), .WDOG_LIMIT(16)) dutW (
    .clk(clk), .rst(wRst), .commit(wCommit), .commit_instr(commitInstr),
    .commit_pc(commitPc), .commit_pre_pc(commitPrePc),
    .trace_valid(wValid), .trace_ready(wReady), .trace_data(wData),
    .fifo_level(wLevel), .retired_cnt(wRetired), .drop_cnt(wDrop),
    .overflow(wOverflow), .halted(wHalted), .timeout(wTimeout)
  );

  int checkCnt = 0;
  int errCnt   = 0;

  task automatic checkVal(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] rec(input logic [31:0] instr, input logic [63:0] pc);
    return {instr, pc + 64'd4, pc};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [31:0] instr, input logic [63:0] pc);
    commit      = c;
    commitInstr = instr;
    commitPc    = pc;
    commitPrePc = pc + 64'd4;
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkVal({pfx, "_valid"},    traceValid, 0);
    checkVal({pfx, "_data"},     traceData, 0);
    checkVal({pfx, "_level"},    fifoLevel, 0);
    checkVal({pfx, "_retired"},  retiredCnt, 0);
    checkVal({pfx, "_drop"},     dropCnt, 0);
    checkVal({pfx, "_overflow"}, overflow, 0);
    checkVal({pfx, "_halted"},   halted, 0);
    checkVal({pfx, "_timeout"},  timeout, 0);
    checkVal({pfx, "_state"},    dut.state, 0);
  endtask

  initial begin
    int unsigned ord [8] = '{2, 3, 4, 5, 6, 7, 10, 11};

    rst = 1'b0; wRst = 1'b0; wCommit = 1'b0; wReady = 1'b0;
    traceReady = 1'b0;
    drive(1'b0, NOP, 64'd0);
    cyc(); cyc();
    checkResetOutputs("reset");
    rst = 1'b1;

    // Three back-to-back commits, sink always ready
    traceReady = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, NOP | (i << 7), 64'h80000000 + 64'(4 * i));
      cyc();
      checkVal("basic_valid", traceValid, 1);
      checkVal("basic_data", traceData, rec(NOP | (i << 7), 64'h80000000 + 64'(4 * i)));
      checkVal("basic_level", fifoLevel, 1);
    end
    drive(1'b0, NOP, 64'd0);
    cyc();
    checkVal("basic_empty", traceValid, 0);
    checkVal("basic_retired", retiredCnt, 3);

    // Overflow: DEPTH+2 commits with sink stalled
    traceReady = 1'b0;
    for (int unsigned i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, NOP, 64'h1000 + 64'(4 * i));
      cyc();
    end
    checkVal("ovf_level", fifoLevel, DEPTH);
    checkVal("ovf_drop", dropCnt, 2);
    checkVal("ovf_flag", overflow, 1);
    checkVal("ovf_head", traceData, rec(NOP, 64'h1000));

    // Full FIFO with simultaneous pop: no drop
    traceReady = 1'b1;
    drive(1'b1, NOP, 64'h1000 + 64'd40);
    cyc();
    checkVal("full_pop_level1", fifoLevel, DEPTH);
    checkVal("full_pop_drop1", dropCnt, 2);
    drive(1'b1, NOP, 64'h1000 + 64'd44);
    cyc();
    checkVal("full_pop_level2", fifoLevel, DEPTH);
    checkVal("full_pop_drop2", dropCnt, 2);
    drive(1'b0, NOP, 64'd0);
    for (int unsigned k = 0; k < 8; k++) begin
      checkVal("drain_order", traceData, rec(NOP, 64'h1000 + 64'(4 * ord[k])));
      cyc();
    end
    checkVal("drain_empty", traceValid, 0);
    checkVal("drain_retired", retiredCnt, 15);

    // ebreak with two entries queued
    traceReady = 1'b0;
    drive(1'b1, NOP, 64'h2000);
    cyc();
    drive(1'b1, NOP, 64'h2004);
    cyc();
    checkVal("eb_level_pre", fifoLevel, 2);
    checkVal("eb_out_a", traceData, rec(NOP, 64'h2000));
    traceReady = 1'b1;
    drive(1'b1, EBREAK, 64'h2008);
    cyc();
    checkVal("eb_state_drain", dut.state, 1);
    checkVal("eb_out_b", traceData, rec(NOP, 64'h2004));
    checkVal("eb_retired", retiredCnt, 18);
    drive(1'b1, NOP, 64'h3000);
    cyc();
    checkVal("eb_out_e", traceData, rec(EBREAK, 64'h2008));
    checkVal("eb_ignore_retired", retiredCnt, 18);
    checkVal("eb_level1", fifoLevel, 1);
    cyc();
    checkVal("eb_empty", traceValid, 0);
    checkVal("eb_not_yet_halted", halted, 0);
    cyc();
    checkVal("eb_halted", halted, 1);
    checkVal("eb_no_timeout", timeout, 0);
    repeat (3) cyc();
    checkVal("halt_retired", retiredCnt, 18);
    checkVal("halt_level", fifoLevel, 0);
    checkVal("halt_drop", dropCnt, 2);
    checkVal("halt_sticky", halted, 1);

    // Reset mid-drain with four entries queued
    rst = 1'b0;
    drive(1'b0, NOP, 64'd0);
    cyc();
    rst = 1'b1;
    traceReady = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, NOP, 64'h4000 + 64'(4 * i));
      cyc();
    end
    drive(1'b1, EBREAK, 64'h400C);
    cyc();
    checkVal("mid_level", fifoLevel, 4);
    checkVal("mid_state", dut.state, 1);
    checkVal("mid_retired", retiredCnt, 4);
    rst = 1'b0;
    drive(1'b0, NOP, 64'd0);
    cyc();
    checkResetOutputs("mid_rst");
    rst = 1'b1;
    traceReady = 1'b1;
    drive(1'b1, NOP, 64'h5000);
    cyc();
    checkVal("post_rst_data", traceData, rec(NOP, 64'h5000));
    checkVal("post_rst_level", fifoLevel, 1);
    drive(1'b0, NOP, 64'd0);
    cyc();

    // Watchdog instance: queue three, then go idle
    wRst = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b0, NOP, 64'h6000 + 64'(4 * i));
      wCommit = 1'b1;
      cyc();
    end
    wCommit = 1'b0;
    repeat (15) cyc();
    checkVal("wdog_before", wTimeout, 0);
    cyc();
    checkVal("wdog_timeout", wTimeout, 1);
    checkVal("wdog_not_halted", wHalted, 0);
    checkVal("wdog_level", wLevel, 3);
    wCommit = 1'b1;
    cyc();
    wCommit = 1'b0;
    checkVal("wdog_ignore_retired", wRetired, 3);
    checkVal("wdog_ignore_level", wLevel, 3);
    wReady = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      checkVal("wdog_drain", wData, rec(NOP, 64'h6000 + 64'(4 * i)));
      cyc();
    end
    checkVal("wdog_empty", wValid, 0);
    checkVal("wdog_still_timeout", wTimeout, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
